// File: rtl/elm_pkg.sv
// Shared definitions for the ELM MAC sequencer: FSM state codes, default layer sizes
// and layer_sel encodings.
package elm_pkg;

  localparam int unsigned N_IN_DEF  = 784;
  localparam int unsigned N_HID_DEF = 128;
  localparam int unsigned N_OUT_DEF = 10;

  // Bit 2 set marks the layer-2 states.
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_L1_RUN   = 3'd1;
  localparam logic [2:0] S_L1_DRAIN = 3'd2;
  localparam logic [2:0] S_L1_WAIT  = 3'd3;
  localparam logic [2:0] S_L2_RUN   = 3'd4;
  localparam logic [2:0] S_L2_DRAIN = 3'd5;
  localparam logic [2:0] S_L2_WR    = 3'd6;
  localparam logic [2:0] S_L2_DONE  = 3'd7;

  localparam logic LSEL_L1 = 1'b0;
  localparam logic LSEL_L2 = 1'b1;

  function automatic logic is_l2_state(input logic [2:0] s);
    return s[2];
  endfunction

  function automatic logic is_run_state(input logic [2:0] s);
    return (s == S_L1_RUN) || (s == S_L2_RUN);
  endfunction

endpackage

// File: rtl/elm_seq_delay.sv
// MEM_LAT-deep shift register carrying {valid, first} so the accumulate strobes line up
// with data returning from the weight and operand memories.
module elm_seq_delay
  import elm_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic valid_i,
  input  logic first_i,
  output logic valid_o,
  output logic first_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] first_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      first_q <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
      first_q <= '0;
    end else begin
      valid_q <= (valid_q << 1) | DEPTH'(valid_i);
      first_q <= (first_q << 1) | DEPTH'(first_i);
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign first_o = first_q[DEPTH-1];

endmodule

// File: rtl/elm_mac_sequencer.sv
// Address/strobe sequencer for the shared ELM multiply-accumulate datapath.
// Optional cycle counter port perf_cycles is built when ELM_MAC_SEQ_PERF_EN is defined.
//
// state      | meaning
// IDLE       | no run; may hold w10mul flags until start_w10mul drops
// L1_RUN     | one layer-1 read beat per cycle, i = 0..N_IN-1
// L1_DRAIN   | MEM_LAT+1 cycles for the pipeline and accumulator to settle
// L1_WAIT    | hidden sum j complete, waiting for store_hlout
// L2_RUN     | one layer-2 read beat per cycle, j = 0..N_HID-1
// L2_DRAIN   | as L1_DRAIN, for layer 2
// L2_WR      | one-cycle write strobe for output k
// L2_DONE    | all outputs written, waiting for start_w21mul to drop
module elm_mac_sequencer
  import elm_pkg::*;
#(
  parameter int unsigned N_IN    = N_IN_DEF,
  parameter int unsigned N_HID   = N_HID_DEF,
  parameter int unsigned N_OUT   = N_OUT_DEF,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned AW      = 17,
  parameter int unsigned IW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_w10mul,
  input  logic          store_hlout,
  input  logic          start_w21mul,
  output logic          layer_sel,
  output logic          rd_en,
  output logic [AW-1:0] w_addr,
  output logic [IW-1:0] src_addr,
  output logic          acc_en,
  output logic          acc_first,
  output logic [IW-1:0] neuron_idx,
  output logic          out_wr_en,
  output logic          w10mulpart_done,
  output logic          w10mul_done,
`ifdef ELM_MAC_SEQ_PERF_EN
  output logic          w21mul_done,
  output logic [31:0]   perf_cycles
`else
  output logic          w21mul_done
`endif
);

  if (MEM_LAT < 1 || MEM_LAT > 3) begin : g_chk_lat
    $error("elm_mac_sequencer: MEM_LAT must be in 1..3");
  end
  if (((64'd1 << AW) < 64'(N_IN) * 64'(N_HID)) ||
      ((64'd1 << AW) < 64'(N_HID) * 64'(N_OUT))) begin : g_chk_aw
    $error("elm_mac_sequencer: AW too narrow for weight memory");
  end
  if (((64'd1 << IW) < 64'(N_IN)) || ((64'd1 << IW) < 64'(N_HID))) begin : g_chk_iw
    $error("elm_mac_sequencer: IW too narrow for operand index");
  end

  localparam logic [IW-1:0] I_LAST     = IW'(N_IN - 1);
  localparam logic [IW-1:0] J_LAST     = IW'(N_HID - 1);
  localparam logic [IW-1:0] K_LAST     = IW'(N_OUT - 1);
  localparam logic [1:0]    DRAIN_LOAD = 2'(MEM_LAT);

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic [IW-1:0] k_q, k_d;
  logic [AW-1:0] w_q, w_d;
  logic [1:0]    drain_q, drain_d;
  logic          hold_q, hold_d;

  logic in_l1, in_l2, run_req, abort;
  logic first_beat, dly_clr, dly_valid, dly_first;

  assign in_l1   = (state_q == S_L1_RUN) || (state_q == S_L1_DRAIN) || (state_q == S_L1_WAIT);
  assign in_l2   = is_l2_state(state_q);
  assign run_req = (in_l1 & start_w10mul) | (in_l2 & start_w21mul);
  assign abort   = (state_q != S_IDLE) && !run_req;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    w_d     = w_q;
    drain_d = drain_q;
    hold_d  = hold_q;

    case (state_q)
      S_IDLE: begin
        // A finished layer 1 keeps its flags up until the FSM releases start_w10mul.
        if (!(hold_q && start_w10mul)) begin
          hold_d = 1'b0;
          if (start_w10mul) begin
            state_d = S_L1_RUN;
            w_d     = '0;
          end else if (start_w21mul) begin
            state_d = S_L2_RUN;
            w_d     = '0;
          end
        end
      end
      S_L1_RUN: begin
        w_d = w_q + AW'(1);
        if (i_q == I_LAST) begin
          i_d     = '0;
          drain_d = DRAIN_LOAD;
          state_d = S_L1_DRAIN;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      S_L1_DRAIN: begin
        if (drain_q == 2'd0) state_d = S_L1_WAIT;
        else                 drain_d = drain_q - 2'd1;
      end
      S_L1_WAIT: begin
        if (store_hlout) begin
          if (j_q == J_LAST) begin
            state_d = S_IDLE;
            hold_d  = 1'b1;
          end else begin
            j_d     = j_q + IW'(1);
            state_d = S_L1_RUN;
          end
        end
      end
      S_L2_RUN: begin
        w_d = w_q + AW'(1);
        if (j_q == J_LAST) begin
          j_d     = '0;
          drain_d = DRAIN_LOAD;
          state_d = S_L2_DRAIN;
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      S_L2_DRAIN: begin
        if (drain_q == 2'd0) state_d = S_L2_WR;
        else                 drain_d = drain_q - 2'd1;
      end
      S_L2_WR: begin
        if (k_q == K_LAST) begin
          state_d = S_L2_DONE;
        end else begin
          k_d     = k_q + IW'(1);
          state_d = S_L2_RUN;
        end
      end
      S_L2_DONE: begin
        state_d = S_L2_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      hold_d  = 1'b0;
    end

    if (state_d == S_IDLE) begin
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
      w_d     = '0;
      drain_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      w_q     <= '0;
      drain_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      w_q     <= w_d;
      drain_q <= drain_d;
      hold_q  <= hold_d;
    end
  end

  assign first_beat = (state_q == S_L1_RUN) ? (i_q == '0) : (j_q == '0);
  assign dly_clr    = (state_d == S_IDLE);

  elm_seq_delay #(
    .DEPTH (MEM_LAT)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (dly_clr),
    .valid_i (rd_en),
    .first_i (first_beat),
    .valid_o (dly_valid),
    .first_o (dly_first)
  );

  // Strobes are gated by the live request so an abort silences them in the same cycle.
  assign rd_en           = run_req && is_run_state(state_q);
  assign acc_en          = run_req && dly_valid;
  assign acc_first       = acc_en && dly_first;
  assign out_wr_en       = run_req && (state_q == S_L2_WR);
  assign w10mulpart_done = (run_req && (state_q == S_L1_WAIT)) || hold_q;
  assign w10mul_done     = (run_req && (state_q == S_L1_WAIT) && (j_q == J_LAST)) || hold_q;
  assign w21mul_done     = run_req && (state_q == S_L2_DONE);

  assign layer_sel  = in_l2 ? LSEL_L2 : LSEL_L1;
  assign w_addr     = w_q;
  assign src_addr   = in_l2 ? j_q : i_q;
  assign neuron_idx = in_l2 ? k_q : j_q;

`ifdef ELM_MAC_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (state_d != S_IDLE) perf_q <= '0;
    end else if (perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: doc/elm_mac_sequencer.md
Name: elm_mac_sequencer

Overview:
- Address and timing sequencer for the shared multiply-accumulate datapath of the ELM classifier.
- Driven by the top-level control FSM through start_w10mul / store_hlout / start_w21mul.
- Walks the input-to-hidden (layer 1) and hidden-to-output (layer 2) weight memories.
- Generates read enables, accumulate strobes and store strobes, and returns w10mulpart_done, w10mul_done and w21mul_done to the FSM.

Parameters:
- N_IN, 784: input pixels per image (layer-1 inner-loop length).
- N_HID, 128: hidden neurons (layer-1 outer loop, layer-2 inner loop).
- N_OUT, 10: output classes (layer-2 outer loop).
- MEM_LAT, 1: read latency in cycles of the weight and operand memories, range 1..3.
- AW, 17: weight address width; must satisfy 2^AW >= max(N_IN*N_HID, N_HID*N_OUT).
- IW, 10: operand and neuron index width; must satisfy 2^IW >= max(N_IN, N_HID).

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-low reset.
- start_w10mul, in, 1: level; layer-1 run request from control FSM.
- store_hlout, in, 1: FSM acknowledge that the hidden output has been stored.
- start_w21mul, in, 1: level; layer-2 run request.
- layer_sel, out, 1: 0 = layer 1, 1 = layer 2; selects weight memory and operand source.
- rd_en, out, 1: read strobe to weight and operand memories.
- w_addr, out, AW: weight address (row-major, outer index × inner length + inner index).
- src_addr, out, IW: operand address (pixel index in layer 1, hidden index in layer 2).
- acc_en, out, 1: accumulate the product arriving this cycle.
- acc_first, out, 1: with acc_en; accumulator loads the product instead of adding it.
- neuron_idx, out, IW: current outer index (hidden j or output k); store address.
- out_wr_en, out, 1: one-cycle strobe to write the layer-2 result at neuron_idx.
- w10mulpart_done, out, 1: current hidden neuron's sum is complete.
- w10mul_done, out, 1: all hidden neurons are complete.
- w21mul_done, out, 1: all outputs are written.

Behaviour:
- Reset: all outputs are 0, all counters are 0, and the state is IDLE.
- States: IDLE, L1_RUN, L1_DRAIN, L1_WAIT, L2_RUN, L2_DRAIN, L2_WR, L2_DONE.
- IDLE:
  - start_w10mul=1 → L1_RUN with j=0, i=0, w_addr=0.
  - Otherwise start_w21mul=1 → L2_RUN with k=0, j=0, w_addr=0.
  - If both are high, layer 1 wins.
- L1_RUN:
  - rd_en=1 for exactly N_IN consecutive cycles; src_addr=i and w_addr increment every cycle.
  - w_addr is a running counter; no multiplier is used.
  - After the beat with i=N_IN-1 → L1_DRAIN.
- acc_en and acc_first are rd_en and the first-beat flag delayed by exactly MEM_LAT cycles, in both layers.
- L1_DRAIN: lasts MEM_LAT+1 cycles (MEM_LAT for the pipeline to empty, plus one for the accumulator register), then → L1_WAIT.
- Layer-1 latency: the first rd_en is at cycle t+1 after start is sampled at edge t; w10mulpart_done rises at t+N_IN+MEM_LAT+2.
- L1_WAIT:
  - w10mulpart_done=1, held until store_hlout is sampled high; it is low the following cycle.
  - w10mul_done=1 in L1_WAIT whenever j=N_HID-1, so the FSM sees it during its store cycle.
  - On store_hlout with j<N_HID-1: j+1, i=0, w_addr continues → L1_RUN.
  - On store_hlout with j=N_HID-1: w10mul_done and w10mulpart_done stay high → IDLE-hold until start_w10mul=0, then IDLE with flags cleared.
- L2_RUN / L2_DRAIN: same beat structure as layer 1, with N_HID inner beats, src_addr=j and layer_sel=1.
- L2_WR: out_wr_en=1 for one cycle with neuron_idx=k.
  - If k<N_OUT-1: k+1 → L2_RUN.
  - Else → L2_DONE.
- L2_DONE: w21mul_done=1 until start_w21mul=0, then IDLE.
- Abort: if the run request of the active layer drops in any non-IDLE state, go to IDLE on the next edge. rd_en, acc_en and all strobes are forced 0 immediately (combinationally qualified), and counters are cleared.
- Reset asserted mid-operation: outputs go to 0 asynchronously; nothing resumes after reset releases.
- w_addr wraps to 0 only at layer start; no other wrap occurs.

Optional Feature:
- Macro: ELM_MAC_SEQ_PERF_EN.
- Defined:
  - Adds output perf_cycles (32-bit). It clears on leaving IDLE, increments every non-IDLE cycle, and holds its value in IDLE until the next run.
  - Saturates at all-ones.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package elm_pkg holds:
  - the state encoding localparams;
  - default N_IN, N_HID and N_OUT;
  - layer_sel encodings L1=0 and L2=1.
- One sub-module, elm_seq_delay: a MEM_LAT-deep shift register carrying {valid, first}, used to produce acc_en and acc_first.

Test Plan (all with N_IN=4, N_HID=3, N_OUT=2, MEM_LAT=1):
1. start_w10mul held high, store_hlout pulsed one cycle after each w10mulpart_done → w_addr 0..11 across three bursts of 4 rd_en; acc_first on beats 0, 4 and 8; w10mulpart_done rises 7 cycles after start; w10mul_done is high in the third wait.
2. Layer-1 wait with store_hlout withheld for 5 cycles → w10mulpart_done held 5 cycles; no rd_en; j unchanged.
3. start_w21mul high → two bursts of 3 rd_en with w_addr 0..5 and layer_sel=1; out_wr_en with neuron_idx=0 then 1; w21mul_done held until start_w21mul drops.
4. start_w10mul dropped mid-burst at i=2 → rd_en and acc_en are 0 in the same cycle and the state is IDLE at the next edge; a restart begins at w_addr=0.
5. rst pulled low during L2_RUN → all outputs are 0 asynchronously; after release, idle until a new request.
6. start_w10mul and start_w21mul raised together → layer 1 runs first; with ELM_MAC_SEQ_PERF_EN defined, perf_cycles equals the total non-IDLE cycle count.
